// File: rtl/reg_file_sb_pkg.sv
// Shared processor constants: architectural register indices used by the
// register file and its scoreboard.
package reg_file_sb_pkg;

   localparam int unsigned ZERO = 0;
   localparam int unsigned V0   = 2;
   localparam int unsigned A0   = 4;
   localparam int unsigned RA   = 31;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue, cleared
// on writeback, plus combinational read-hazard and next-cycle read-busy terms.
module reg_scoreboard
   import reg_file_sb_pkg::*;
#(
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           i_iss_valid,
   input  logic [ADDR_W-1:0]              i_iss_rd,
   input  logic                           i_clr_valid,
   input  logic [ADDR_W-1:0]              i_clr_idx,
   input  logic [NUM_RD-1:0][ADDR_W-1:0]  i_rd_addr,
   output logic [(2**ADDR_W)-1:0]         o_busy_vec,
   output logic                           o_hazard,
   output logic [NUM_RD-1:0]              o_rd_busy_nxt
);

   localparam int NUM_REGS = 2**ADDR_W;

   logic [NUM_REGS-1:0] r_busy;
   logic [NUM_REGS-1:0] w_set;
   logic [NUM_REGS-1:0] w_clr;
   logic [NUM_REGS-1:0] w_busy_nxt;
   logic [NUM_RD-1:0]   w_haz;

   assign w_set = (i_iss_valid && (i_iss_rd != '0)) ? (NUM_REGS'(1) << i_iss_rd) : '0;
   assign w_clr = i_clr_valid ? (NUM_REGS'(1) << i_clr_idx) : '0;
   // Set is applied after clear so a same-edge reissue keeps the register busy.
   assign w_busy_nxt = ((r_busy & ~w_clr) | w_set) & ~NUM_REGS'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_busy <= '0;
      else        r_busy <= w_busy_nxt;
   end

   always_comb begin
      w_haz         = '0;
      o_rd_busy_nxt = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         if (i_rd_addr[p] != '0) begin
            if (i_clr_valid && (i_clr_idx == i_rd_addr[p])) begin
               o_rd_busy_nxt[p] = w_set[i_rd_addr[p]];
            end else begin
               w_haz[p]         = r_busy[i_rd_addr[p]];
               o_rd_busy_nxt[p] = r_busy[i_rd_addr[p]];
            end
         end
      end
   end

   assign o_hazard   = |w_haz;
   assign o_busy_vec = r_busy;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with write-first bypass, link writeback and a
// pending-write scoreboard; register 0 is hardwired to zero.
module reg_file_sb
   import reg_file_sb_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int LINK_REG = RA
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   output logic [NUM_RD-1:0]          rd_busy,
   input  logic                       iss_valid,
   input  logic [ADDR_W-1:0]          iss_rd,
   input  logic                       wb_valid,
   input  logic [ADDR_W-1:0]          wb_rd,
   input  logic                       wb_link,
   input  logic [DATA_W-1:0]          wb_data,
   output logic                       hazard,
   output logic [(2**ADDR_W)-1:0]     busy_vec
);

   localparam int NUM_REGS = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(LINK_REG);

   if (NUM_RD < 1) begin : g_bad_num_rd
      $error("reg_file_sb: NUM_RD must be at least 1");
   end
   if ((LINK_REG < 0) || (LINK_REG >= NUM_REGS)) begin : g_bad_link
      $error("reg_file_sb: LINK_REG out of register range");
   end

   logic [NUM_RD-1:0][ADDR_W-1:0] w_rd_addr;
   logic [NUM_RD-1:0][DATA_W-1:0] w_rd_val;
   logic [NUM_RD-1:0][DATA_W-1:0] r_rd_data;
   logic [NUM_RD-1:0]             w_rd_busy_nxt;
   logic [NUM_RD-1:0]             r_rd_busy;
   logic [ADDR_W-1:0]             w_wb_idx;
   logic                          w_wr_en;
   logic [DATA_W-1:0]             r_regs [NUM_REGS];

   assign w_rd_addr = rd_addr;
   assign w_wb_idx  = wb_link ? LINK_IDX : wb_rd;
   assign w_wr_en   = wb_valid && (w_wb_idx != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      end else if (w_wr_en) begin
         r_regs[w_wb_idx] <= wb_data;
      end
   end

   // Write-first: a same-edge writeback to the addressed register is forwarded.
   always_comb begin
      w_rd_val = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         if (w_rd_addr[p] == '0)                         w_rd_val[p] = '0;
         else if (w_wr_en && (w_wb_idx == w_rd_addr[p])) w_rd_val[p] = wb_data;
         else                                            w_rd_val[p] = r_regs[w_rd_addr[p]];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_data <= '0;
         r_rd_busy <= '0;
      end else begin
         r_rd_data <= w_rd_val;
         r_rd_busy <= w_rd_busy_nxt;
      end
   end

   reg_scoreboard #(
      .ADDR_W (ADDR_W),
      .NUM_RD (NUM_RD)
   ) u_sb (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_iss_valid   (iss_valid),
      .i_iss_rd      (iss_rd),
      .i_clr_valid   (wb_valid),
      .i_clr_idx     (w_wb_idx),
      .i_rd_addr     (w_rd_addr),
      .o_busy_vec    (busy_vec),
      .o_hazard      (hazard),
      .o_rd_busy_nxt (w_rd_busy_nxt)
   );

   assign rd_data = r_rd_data;
   assign rd_busy = r_rd_busy;

endmodule

// File: tb/tb_reg_file_sb.sv
// Randomized + directed bench for reg_file_sb against an array-based model.
module tb_reg_file_sb;

   localparam int DW   = 32;
   localparam int AW   = 5;
   localparam int NR   = 2;
   localparam int NREG = 32;
   localparam int LINK = 31;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NR*AW-1:0]  rd_addr;
   logic [NR*DW-1:0]  rd_data;
   logic [NR-1:0]     rd_busy;
   logic              iss_valid;
   logic [AW-1:0]     iss_rd;
   logic              wb_valid;
   logic [AW-1:0]     wb_rd;
   logic              wb_link;
   logic [DW-1:0]     wb_data;
   logic              hazard;
   logic [NREG-1:0]   busy_vec;

   int n_checks = 0;
   int n_err    = 0;
   bit chk_on   = 1'b0;

   reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .LINK_REG(LINK)) dut (
      .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
      .rd_busy(rd_busy), .iss_valid(iss_valid), .iss_rd(iss_rd),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_link(wb_link),
      .wb_data(wb_data), .hazard(hazard), .busy_vec(busy_vec)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [DW-1:0]   m_regs [NREG];
   logic [NREG-1:0] m_busy;
   logic [DW-1:0]   m_rd_data [NR];
   logic [NR-1:0]   m_rd_busy;

   function automatic int eff();
      return wb_link ? LINK : int'(wb_rd);
   endfunction

   function automatic int addr(input int p);
      return int'(rd_addr[p*AW +: AW]);
   endfunction

   function automatic logic [DW-1:0] exp_read(input int a);
      if (a == 0) return '0;
      if (wb_valid && eff() == a) return wb_data;
      return m_regs[a];
   endfunction

   function automatic logic exp_rbusy(input int a);
      if (a == 0) return 1'b0;
      if (wb_valid && eff() == a) return iss_valid && (int'(iss_rd) == a);
      return m_busy[a];
   endfunction

   function automatic logic [NREG-1:0] next_busy();
      logic [NREG-1:0] b;
      b = m_busy;
      if (wb_valid)  b[eff()] = 1'b0;
      if (iss_valid) b[iss_rd] = 1'b1;
      b[0] = 1'b0;
      return b;
   endfunction

   function automatic logic exp_hazard();
      for (int p = 0; p < NR; p++)
         if (addr(p) != 0 && m_busy[addr(p)] && !(wb_valid && eff() == addr(p))) return 1'b1;
      return 1'b0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) m_regs[i] <= '0;
         for (int p = 0; p < NR; p++) m_rd_data[p] <= '0;
         m_busy    <= '0;
         m_rd_busy <= '0;
      end else begin
         for (int p = 0; p < NR; p++) begin
            m_rd_data[p] <= exp_read(addr(p));
            m_rd_busy[p] <= exp_rbusy(addr(p));
         end
         if (wb_valid && eff() != 0) m_regs[eff()] <= wb_data;
         m_busy <= next_busy();
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         for (int p = 0; p < NR; p++) begin
            chk("model rd_data", 64'(rd_data[p*DW +: DW]), 64'(m_rd_data[p]));
            chk("model rd_busy", 64'(rd_busy[p]), 64'(m_rd_busy[p]));
         end
         chk("model busy_vec", 64'(busy_vec), 64'(m_busy));
         chk("model hazard", 64'(hazard), 64'(exp_hazard()));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      iss_valid = 1'b0; iss_rd = '0;
      wb_valid = 1'b0; wb_rd = '0; wb_link = 1'b0; wb_data = '0;
   endtask

   task automatic set_rd(input int a0, input int a1);
      rd_addr = {AW'(a1), AW'(a0)};
   endtask

   task automatic do_wb(input int r, input logic lnk, input logic [DW-1:0] d);
      wb_valid = 1'b1; wb_rd = AW'(r); wb_link = lnk; wb_data = d;
   endtask

   function automatic int rand_reg();
      return ($urandom_range(0, 4) == 0) ? 31 : int'($urandom_range(0, 12));
   endfunction

   initial begin
      rst_n = 1'b0;
      idle();
      set_rd(0, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk_on = 1'b1;

      // reset state, read regs 5/6
      set_rd(5, 6);
      tick();
      chk("reset rd_data0", 64'(rd_data[31:0]), 64'h0);
      chk("reset rd_data1", 64'(rd_data[63:32]), 64'h0);
      chk("reset rd_busy", 64'(rd_busy), 64'h0);
      chk("reset busy_vec", 64'(busy_vec), 64'h0);

      // write-first bypass
      do_wb(5, 1'b0, 32'hDEADBEEF);
      set_rd(5, 6);
      tick();
      chk("bypass rd5", 64'(rd_data[31:0]), 64'hDEADBEEF);
      do_wb(0, 1'b0, 32'h1234);
      set_rd(0, 5);
      tick();
      chk("reg0 bypass", 64'(rd_data[31:0]), 64'h0);
      chk("reg5 stored", 64'(rd_data[63:32]), 64'hDEADBEEF);
      do_wb(7, 1'b0, 32'h77);
      tick();
      chk("reg0 stored", 64'(rd_data[31:0]), 64'h0);

      // link writeback
      do_wb(7, 1'b1, 32'h00400008);
      set_rd(31, 7);
      tick();
      idle();
      chk("link bypass", 64'(rd_data[31:0]), 64'h00400008);
      chk("link reg7 kept", 64'(rd_data[63:32]), 64'h77);
      tick();
      chk("link reg31", 64'(rd_data[31:0]), 64'h00400008);
      chk("link reg7 kept2", 64'(rd_data[63:32]), 64'h77);

      // issue then resolve
      iss_valid = 1'b1; iss_rd = 5'd8;
      tick();
      idle();
      set_rd(8, 0);
      #1 chk("hazard set", 64'(hazard), 64'h1);
      chk("busy8 set", 64'(busy_vec[8]), 64'h1);
      tick();
      chk("rd_busy8", 64'(rd_busy[0]), 64'h1);
      do_wb(8, 1'b0, 32'h88);
      #1 chk("hazard resolved", 64'(hazard), 64'h0);
      tick();
      idle();
      chk("busy8 cleared", 64'(busy_vec[8]), 64'h0);
      chk("rd_busy8 cleared", 64'(rd_busy[0]), 64'h0);

      // same-edge issue and writeback
      iss_valid = 1'b1; iss_rd = 5'd9;
      do_wb(9, 1'b0, 32'hCAFE0009);
      set_rd(9, 9);
      tick();
      idle();
      chk("set+clr busy9", 64'(busy_vec[9]), 64'h1);
      chk("set+clr data", 64'(rd_data[31:0]), 64'hCAFE0009);
      chk("set+clr rd_busy", 64'(rd_busy), 64'h3);
      tick();
      chk("reg9 stored", 64'(rd_data[63:32]), 64'hCAFE0009);

      // async reset mid-sequence with populated state
      do_wb(3, 1'b0, 32'h33);
      #2 rst_n = 1'b0;
      #1;
      chk("async rd_data", 64'(rd_data), 64'h0);
      chk("async busy_vec", 64'(busy_vec), 64'h0);
      chk("async rd_busy", 64'(rd_busy), 64'h0);
      tick();
      idle();
      rst_n = 1'b1;
      set_rd(3, 9);
      tick();
      chk("reset wb dropped", 64'(rd_data[31:0]), 64'h0);
      chk("reset reg9 cleared", 64'(rd_data[63:32]), 64'h0);

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         iss_valid = ($urandom_range(0, 2) == 0);
         iss_rd    = AW'(rand_reg());
         wb_valid  = ($urandom_range(0, 1) == 0);
         wb_rd     = AW'(rand_reg());
         wb_link   = ($urandom_range(0, 5) == 0);
         wb_data   = $urandom;
         set_rd(rand_reg(), rand_reg());
         if (n == 300) begin
            #2 rst_n = 1'b0;
            #2 rst_n = 1'b1;
         end
         tick();
      end
      idle();
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
